// File: rtl/imem_wr_arbiter_pkg.sv
// Shared constants, state encoding and write-beat type for the imem write arbiter.
package imem_wr_arbiter_pkg;

   localparam int unsigned IMEM_DEPTH = 16384;
   localparam int unsigned IMEM_AW    = 14;
   localparam int unsigned IMEM_DW    = 32;
   localparam int unsigned IMEM_BW    = 4;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_CLEAR = 1'b1
   } imem_state_e;

   // Round-robin pointer value: the requester granted most recently.
   typedef enum logic {
      RR_A = 1'b0,
      RR_B = 1'b1
   } rr_sel_e;

   typedef struct packed {
      logic [IMEM_AW-1:0] addr;
      logic [IMEM_DW-1:0] data;
      logic [IMEM_BW-1:0] be;
   } imem_wr_t;

endpackage

// File: rtl/imem_rr_arb2.sv
// Two-requester round-robin grant. The pointer names the last granted
// requester; on contention the other requester wins. Grants are only ever
// given to a valid requester, so a grant is an accepted transfer.
module imem_rr_arb2
   import imem_wr_arbiter_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic a_req,
   input  logic b_req,
   output logic a_gnt,
   output logic b_gnt
);

   rr_sel_e ptr;

   // Grant selection from pointer and requests, suppressed when disabled.
   always_comb begin
      a_gnt = 1'b0;
      b_gnt = 1'b0;
      if (en) begin
         if (a_req && b_req) begin
            if (ptr == RR_B) a_gnt = 1'b1;
            else             b_gnt = 1'b1;
         end else begin
            a_gnt = a_req;
            b_gnt = b_req;
         end
      end
   end

   // Pointer follows the accepted transfer; reset favours A on first contention.
   always_ff @(posedge clk) begin
      if (!rst)       ptr <= RR_B;
      else if (a_gnt) ptr <= RR_A;
      else if (b_gnt) ptr <= RR_B;
   end

endmodule

// File: rtl/imem_wr_arbiter.sv
// imem write-port arbiter: merges bootloader (A) and CPU store (B) writes
// onto one registered imem port, and can zero-fill the whole imem.
module imem_wr_arbiter
   import imem_wr_arbiter_pkg::*;
#(
   parameter int unsigned DEPTH = IMEM_DEPTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr_start,
   output logic               clr_busy,
   output logic               clr_done,
   input  logic               a_valid,
   output logic               a_ready,
   input  logic [IMEM_AW-1:0] a_addr,
   input  logic [IMEM_DW-1:0] a_data,
   input  logic [IMEM_BW-1:0] a_be,
   input  logic               b_valid,
   output logic               b_ready,
   input  logic [IMEM_AW-1:0] b_addr,
   input  logic [IMEM_DW-1:0] b_data,
   input  logic [IMEM_BW-1:0] b_be,
   output logic               imem_ena,
   output logic [IMEM_BW-1:0] imem_wea,
   output logic [IMEM_AW-1:0] imem_addra,
   output logic [IMEM_DW-1:0] imem_dina
);

   localparam logic [IMEM_AW-1:0] CLR_LAST = IMEM_AW'(DEPTH - 1);

   imem_state_e        state;
   imem_state_e        state_n;
   logic [IMEM_AW-1:0] clr_cnt;
   logic               clr_last;
   logic               arb_en;
   logic               a_gnt;
   logic               b_gnt;
   logic               wr_go;
   imem_wr_t           wr_sel;

   assign clr_last = (clr_cnt == CLR_LAST);
   assign a_ready  = a_gnt;
   assign b_ready  = b_gnt;

   imem_rr_arb2 u_arb (
      .clk   (clk),
      .rst   (rst),
      .en    (arb_en),
      .a_req (a_valid),
      .b_req (b_valid),
      .a_gnt (a_gnt),
      .b_gnt (b_gnt)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) state <= ST_RUN;
      else      state <= state_n;
   end

   // Next state: enter CLEAR on request, leave once the last address issues.
   always_comb begin
      state_n = state;
      case (state)
         ST_RUN:   if (clr_start) state_n = ST_CLEAR;
         ST_CLEAR: if (clr_last)  state_n = ST_RUN;
         default:  state_n = ST_RUN;
      endcase
   end

   // Arbiter enable and write-beat selection for this cycle.
   // Readies are held low in reset and in the clr_start cycle itself.
   always_comb begin
      arb_en = rst && (state == ST_RUN) && !clr_start;
      wr_go  = 1'b0;
      wr_sel = '0;
      if (state == ST_CLEAR) begin
         wr_go       = 1'b1;
         wr_sel.addr = clr_cnt;
         wr_sel.data = '0;
         wr_sel.be   = '1;
      end else if (a_gnt) begin
         wr_go  = |a_be;
         wr_sel = '{addr: a_addr, data: a_data, be: a_be};
      end else if (b_gnt) begin
         wr_go  = |b_be;
         wr_sel = '{addr: b_addr, data: b_data, be: b_be};
      end
   end

   // Clear address counter: walks 0..DEPTH-1 in CLEAR, parked at 0 otherwise.
   always_ff @(posedge clk) begin
      if (!rst)                   clr_cnt <= '0;
      else if (state != ST_CLEAR) clr_cnt <= '0;
      else if (clr_last)          clr_cnt <= '0;
      else                        clr_cnt <= clr_cnt + IMEM_AW'(1);
   end

   // Registered imem port; address/data hold when no write is issued.
   always_ff @(posedge clk) begin
      if (!rst) begin
         imem_ena   <= 1'b0;
         imem_wea   <= '0;
         imem_addra <= '0;
         imem_dina  <= '0;
      end else begin
         imem_ena <= wr_go;
         imem_wea <= wr_go ? wr_sel.be : '0;
         if (wr_go) begin
            imem_addra <= wr_sel.addr;
            imem_dina  <= wr_sel.data;
         end
      end
   end

   // Clear status, aligned with the registered port: busy spans the first
   // issue through the last write on the port, done marks that last write.
   always_ff @(posedge clk) begin
      if (!rst) begin
         clr_busy <= 1'b0;
         clr_done <= 1'b0;
      end else begin
         clr_busy <= ((state == ST_RUN) && clr_start) || (state == ST_CLEAR);
         clr_done <= (state == ST_CLEAR) && clr_last;
      end
   end

endmodule

// File: tb/tb_imem_wr_arbiter.sv
// Scoreboard bench for imem_wr_arbiter (DEPTH=16).
module tb_imem_wr_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        clr_start;
   logic        clr_busy;
   logic        clr_done;
   logic        a_valid, a_ready;
   logic [13:0] a_addr;
   logic [31:0] a_data;
   logic [3:0]  a_be;
   logic        b_valid, b_ready;
   logic [13:0] b_addr;
   logic [31:0] b_data;
   logic [3:0]  b_be;
   logic        imem_ena;
   logic [3:0]  imem_wea;
   logic [13:0] imem_addra;
   logic [31:0] imem_dina;

   int n_checks = 0;
   int n_pass   = 0;
   logic [49:0] exp_q[$];

   imem_wr_arbiter #(.DEPTH(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .clr_start  (clr_start),
      .clr_busy   (clr_busy),
      .clr_done   (clr_done),
      .a_valid    (a_valid),
      .a_ready    (a_ready),
      .a_addr     (a_addr),
      .a_data     (a_data),
      .a_be       (a_be),
      .b_valid    (b_valid),
      .b_ready    (b_ready),
      .b_addr     (b_addr),
      .b_data     (b_data),
      .b_be       (b_be),
      .imem_ena   (imem_ena),
      .imem_wea   (imem_wea),
      .imem_addra (imem_addra),
      .imem_dina  (imem_dina)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, required %h", name, act, exp);
   endtask

   task automatic push(input logic [13:0] addr, input logic [31:0] data, input logic [3:0] be);
      exp_q.push_back({addr, data, be});
   endtask

   // Inputs are driven 1 time unit after the falling edge; checks follow #1 later.
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // Monitor: every write seen on the imem port must match the next expected beat.
   always @(negedge clk) begin
      if (imem_ena) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_write: got addr=%h data=%h wea=%h, required no write",
                     imem_addra, imem_dina, imem_wea);
         end else begin
            check("imem_write{addr,data,wea}", 64'({imem_addra, imem_dina, imem_wea}),
                  64'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_done;
      rst = 1'b0; clr_start = 1'b0;
      a_valid = 1'b1; a_addr = '0; a_data = '0; a_be = '0;
      b_valid = 1'b0; b_addr = '0; b_data = '0; b_be = '0;

      // Reset state, with A requesting throughout reset.
      repeat (3) step();
      #1;
      check("reset_a_ready",    64'(a_ready),    64'(0));
      check("reset_imem_ena",   64'(imem_ena),   64'(0));
      check("reset_imem_wea",   64'(imem_wea),   64'(0));
      check("reset_imem_addra", 64'(imem_addra), 64'(0));
      check("reset_imem_dina",  64'(imem_dina),  64'(0));
      check("reset_clr_busy",   64'(clr_busy),   64'(0));
      check("reset_clr_done",   64'(clr_done),   64'(0));

      // Single A write.
      step();
      rst = 1'b1; a_addr = 14'h0010; a_data = 32'hDEADBEEF; a_be = 4'hF;
      #1;
      check("single_a_ready", 64'(a_ready), 64'(1));
      check("single_b_ready", 64'(b_ready), 64'(0));
      push(14'h0010, 32'hDEADBEEF, 4'hF);
      step();
      a_valid = 1'b0;

      // Contention after a fresh reset: A,B,A,B.
      step(); rst = 1'b0;
      step(); rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         a_valid = 1'b1; a_addr = 14'h1; a_data = 32'h11111111; a_be = 4'hF;
         b_valid = 1'b1; b_addr = 14'h2; b_data = 32'h22222222; b_be = 4'h3;
         #1;
         check("rr_a_ready", 64'(a_ready), 64'((k % 2) == 0));
         check("rr_b_ready", 64'(b_ready), 64'((k % 2) == 1));
         if ((k % 2) == 0) push(14'h1, 32'h11111111, 4'hF);
         else              push(14'h2, 32'h22222222, 4'h3);
      end
      step();
      a_valid = 1'b0; b_valid = 1'b0;
      #1;
      check("idle_a_ready", 64'(a_ready), 64'(0));
      check("idle_b_ready", 64'(b_ready), 64'(0));

      // Zero byte-enable transfer is consumed without a write.
      step();
      b_valid = 1'b1; b_addr = 14'h5; b_data = 32'h12345678; b_be = 4'h0;
      #1;
      check("be0_b_ready", 64'(b_ready), 64'(1));
      step();
      check("be0_imem_ena", 64'(imem_ena), 64'(0));
      check("be0_imem_wea", 64'(imem_wea), 64'(0));
      b_addr = 14'h6; b_data = 32'h00AB0000; b_be = 4'b0100;
      #1;
      check("be4_b_ready", 64'(b_ready), 64'(1));
      push(14'h6, 32'h00AB0000, 4'b0100);
      step();
      b_valid = 1'b0;
      step();

      // Full clear with B held valid; B is accepted when the clear ends.
      for (int c = 0; c <= 18; c++) begin
         if (c > 0) step();
         if (c == 0) begin
            clr_start = 1'b1;
            b_valid = 1'b1; b_addr = 14'h20; b_data = 32'hCAFEF00D; b_be = 4'hF;
            for (int i = 0; i < 16; i++) push(14'(i), 32'h0, 4'hF);
         end
         if (c == 1)  clr_start = 1'b0;
         if (c == 18) b_valid = 1'b0;
         #1;
         check("clr_busy", 64'(clr_busy), 64'(c >= 1 && c <= 17));
         check("clr_done", 64'(clr_done), 64'(c == 17));
         if (c <= 16) check("clr_b_ready_low", 64'(b_ready), 64'(0));
         if (c == 17) begin
            check("clr_done_addr", 64'(imem_addra), 64'(15));
            check("post_clr_b_ready", 64'(b_ready), 64'(1));
            push(14'h20, 32'hCAFEF00D, 4'hF);
         end
      end
      step();

      // clr_start repeated during a clear is ignored.
      n_done = 0;
      for (int c = 0; c <= 20; c++) begin
         if (c > 0) step();
         if (c == 0) begin
            clr_start = 1'b1;
            for (int i = 0; i < 16; i++) push(14'(i), 32'h0, 4'hF);
         end
         if (c == 1) clr_start = 1'b0;
         if (c == 3) clr_start = 1'b1;
         if (c == 4) clr_start = 1'b0;
         #1;
         if (clr_done) n_done++;
         check("reclr_busy", 64'(clr_busy), 64'(c >= 1 && c <= 17));
      end
      check("reclr_done_count", 64'(n_done), 64'(1));
      check("reclr_queue_drained", 64'(exp_q.size()), 64'(0));

      // Reset in the middle of a clear aborts it.
      n_done = 0;
      for (int c = 0; c <= 8; c++) begin
         if (c > 0) step();
         if (c == 0) begin
            clr_start = 1'b1;
            for (int i = 0; i < 4; i++) push(14'(i), 32'h0, 4'hF);
         end
         if (c == 1) clr_start = 1'b0;
         if (c == 5) rst = 1'b0;
         if (c == 6) begin
            check("abort_imem_ena", 64'(imem_ena), 64'(0));
            check("abort_clr_busy", 64'(clr_busy), 64'(0));
            rst = 1'b1;
            a_valid = 1'b1; a_addr = 14'h3FFF; a_data = 32'h5A5A5A5A; a_be = 4'h8;
         end
         if (c == 7) a_valid = 1'b0;
         #1;
         if (c >= 6 && clr_done) n_done++;
         if (c == 6) begin
            check("abort_run_a_ready", 64'(a_ready), 64'(1));
            push(14'h3FFF, 32'h5A5A5A5A, 4'h8);
         end
      end
      check("abort_no_clr_done", 64'(n_done), 64'(0));
      repeat (20) step();
      check("final_queue_drained", 64'(exp_q.size()), 64'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
